// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - two-requester register-file write-port arbiter with pending-write mask
//
// Shares one register-file write port between requester A (pipeline writeback)
// and requester B (multi-cycle unit writeback). Each requester owns a 1-entry
// holding buffer behind a valid/ready handshake; a round-robin pointer picks
// between them when both buffers are full.
//
// Optional feature macro: RF_WR_BYPASS_EN (adds read-bypass ports rd1/rd2).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   a_valid/a_sel/a_data     requester A write request, a_ready back
//   b_valid/b_sel/b_data     requester B write request, b_ready back
//   write/writeregsel/writedata  register-file write port
//   pend_mask                bit i set while a buffered write targets register i
//   conflict_cnt             saturating count of cycles with both buffers full
//   [bypass] rd1sel/rd2sel, rf_rd1data/rf_rd2data in; rd1data/rd2data out
module rf_wr_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic [ADDR_W-1:0]    a_sel,
    input  logic [DATA_W-1:0]    a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [ADDR_W-1:0]    b_sel,
    input  logic [DATA_W-1:0]    b_data,
    output logic                 b_ready,
`ifdef RF_WR_BYPASS_EN
    input  logic [ADDR_W-1:0]    rd1sel,
    input  logic [ADDR_W-1:0]    rd2sel,
    input  logic [DATA_W-1:0]    rf_rd1data,
    input  logic [DATA_W-1:0]    rf_rd2data,
    output logic [DATA_W-1:0]    rd1data,
    output logic [DATA_W-1:0]    rd2data,
`endif
    output logic                 write,
    output logic [ADDR_W-1:0]    writeregsel,
    output logic [DATA_W-1:0]    writedata,
    output logic [(1<<ADDR_W)-1:0] pend_mask,
    output logic [CNT_W-1:0]     conflict_cnt
);

    localparam int NREG = 1 << ADDR_W;

    logic              a_full_q, a_full_d;
    logic [ADDR_W-1:0] a_sel_q,  a_sel_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic              b_full_q, b_full_d;
    logic [ADDR_W-1:0] b_sel_q,  b_sel_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;
    logic              rr_q,     rr_d;      // 0 = A preferred, 1 = B preferred
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    logic a_grant, b_grant, both_full;

    always_comb begin
        both_full = a_full_q & b_full_q;
        // Grants are suppressed during reset so a buffered write never reaches
        // the rf in the same cycle the buffers are being discarded.
        a_grant = ~rst & a_full_q & (~b_full_q | ~rr_q);
        b_grant = ~rst & b_full_q & (~a_full_q |  rr_q);

        a_ready = ~a_full_q | a_grant;
        b_ready = ~b_full_q | b_grant;

        write       = a_grant | b_grant;
        writeregsel = '0;
        writedata   = '0;
        if (a_grant) begin
            writeregsel = a_sel_q;
            writedata   = a_data_q;
        end else if (b_grant) begin
            writeregsel = b_sel_q;
            writedata   = b_data_q;
        end

        pend_mask = '0;
        for (int i = 0; i < NREG; i++) begin
            if ((a_full_q && a_sel_q == ADDR_W'(i)) || (b_full_q && b_sel_q == ADDR_W'(i)))
                pend_mask[i] = 1'b1;
        end
        conflict_cnt = cnt_q;
    end

    always_comb begin
        a_full_d = a_full_q & ~a_grant;
        a_sel_d  = a_sel_q;
        a_data_d = a_data_q;
        if (a_valid && a_ready) begin
            a_full_d = 1'b1;
            a_sel_d  = a_sel;
            a_data_d = a_data;
        end

        b_full_d = b_full_q & ~b_grant;
        b_sel_d  = b_sel_q;
        b_data_d = b_data_q;
        if (b_valid && b_ready) begin
            b_full_d = 1'b1;
            b_sel_d  = b_sel;
            b_data_d = b_data;
        end

        rr_d  = both_full ? ~rr_q : rr_q;
        cnt_d = (both_full && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_full_q <= 1'b0;
            a_sel_q  <= '0;
            a_data_q <= '0;
            b_full_q <= 1'b0;
            b_sel_q  <= '0;
            b_data_q <= '0;
            rr_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_full_q <= a_full_d;
            a_sel_q  <= a_sel_d;
            a_data_q <= a_data_d;
            b_full_q <= b_full_d;
            b_sel_q  <= b_sel_d;
            b_data_q <= b_data_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef RF_WR_BYPASS_EN
    // When both buffers hold the same register, the buffer rr does not point
    // at is the more recently granted one, so its data is the newest value.
    always_comb begin
        rd1data = rf_rd1data;
        if (a_full_q && b_full_q && a_sel_q == rd1sel && b_sel_q == rd1sel)
            rd1data = rr_q ? a_data_q : b_data_q;
        else if (a_full_q && a_sel_q == rd1sel)
            rd1data = a_data_q;
        else if (b_full_q && b_sel_q == rd1sel)
            rd1data = b_data_q;

        rd2data = rf_rd2data;
        if (a_full_q && b_full_q && a_sel_q == rd2sel && b_sel_q == rd2sel)
            rd2data = rr_q ? a_data_q : b_data_q;
        else if (a_full_q && a_sel_q == rd2sel)
            rd2data = a_data_q;
        else if (b_full_q && b_sel_q == rd2sel)
            rd2data = b_data_q;
    end
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - directed self-checking bench for rf_wr_arbiter
module tb_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [2:0]  a_sel, b_sel;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic [7:0]  pend_mask;
    logic [7:0]  conflict_cnt;
`ifdef RF_WR_BYPASS_EN
    logic [2:0]  rd1sel, rd2sel;
    logic [15:0] rf_rd1data, rf_rd2data, rd1data, rd2data;
`endif

    logic [15:0] rf_model [8];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Register file the arbiter writes into.
    always @(posedge clk) if (write) rf_model[writeregsel] <= writedata;

    rf_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data), .b_ready(b_ready),
`ifdef RF_WR_BYPASS_EN
        .rd1sel(rd1sel), .rd2sel(rd2sel), .rf_rd1data(rf_rd1data), .rf_rd2data(rf_rd2data),
        .rd1data(rd1data), .rd2data(rd2data),
`endif
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .pend_mask(pend_mask), .conflict_cnt(conflict_cnt)
    );

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_sel = '0; b_sel = '0; a_data = '0; b_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({write, writeregsel, writedata, pend_mask, conflict_cnt, a_ready, b_ready} !== {1'b0, 3'd0, 16'h0, 8'h0, 8'h0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got w=%b sel=%0d data=%h pend=%h cnt=%0d ar=%b br=%b, want 0 0 0000 00 0 1 1",
                     write, writeregsel, writedata, pend_mask, conflict_cnt, a_ready, b_ready);
        end
    endtask

    task automatic test_single_a();
        do_reset();
        a_valid = 1'b1; a_sel = 3'd3; a_data = 16'h1234;
        @(negedge clk);
        a_valid = 1'b0;
        n_vec++;
        if ({write, writeregsel, writedata, pend_mask} !== {1'b1, 3'd3, 16'h1234, 8'h08}) begin
            n_err++;
            $display("FAIL single_a_write: got w=%b sel=%0d data=%h pend=%h, want 1 3 1234 08",
                     write, writeregsel, writedata, pend_mask);
        end
        @(negedge clk);
        n_vec++;
        if ({write, pend_mask} !== {1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL single_a_after: got w=%b pend=%h, want 0 00", write, pend_mask);
        end
    endtask

    task automatic test_dual_accept();
        do_reset();
        a_valid = 1'b1; a_sel = 3'd1; a_data = 16'hAAAA;
        b_valid = 1'b1; b_sel = 3'd2; b_data = 16'h5555;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        n_vec++;
        if ({write, writeregsel, writedata, pend_mask, a_ready, b_ready} !== {1'b1, 3'd1, 16'hAAAA, 8'h06, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL dual_first_a: got w=%b sel=%0d data=%h pend=%h ar=%b br=%b, want 1 1 aaaa 06 1 0",
                     write, writeregsel, writedata, pend_mask, a_ready, b_ready);
        end
        @(negedge clk);
        n_vec++;
        if ({write, writeregsel, writedata, conflict_cnt, pend_mask} !== {1'b1, 3'd2, 16'h5555, 8'd1, 8'h04}) begin
            n_err++;
            $display("FAIL dual_second_b: got w=%b sel=%0d data=%h cnt=%0d pend=%h, want 1 2 5555 1 04",
                     write, writeregsel, writedata, conflict_cnt, pend_mask);
        end
        @(negedge clk);
        n_vec++;
        if ({write, conflict_cnt} !== {1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL dual_idle: got w=%b cnt=%0d, want 0 1", write, conflict_cnt);
        end
        // rr should now point at B: a fresh conflict must grant B first.
        a_valid = 1'b1; a_sel = 3'd0; a_data = 16'h0A0A;
        b_valid = 1'b1; b_sel = 3'd7; b_data = 16'h0B0B;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        n_vec++;
        if ({write, writeregsel, writedata} !== {1'b1, 3'd7, 16'h0B0B}) begin
            n_err++;
            $display("FAIL dual_rr_is_b: got w=%b sel=%0d data=%h, want 1 7 0b0b", write, writeregsel, writedata);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_valid = 1'b1; a_sel = 3'd1; a_data = 16'hA000;
        b_valid = 1'b1; b_sel = 3'd6; b_data = 16'hB000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_vec++;
            if ({write, writeregsel, a_ready, b_ready, conflict_cnt} !==
                {1'b1, (k % 2 == 0) ? 3'd1 : 3'd6, (k % 2 == 0), (k % 2 == 1), 8'(k)}) begin
                n_err++;
                $display("FAIL b2b_cycle%0d: got w=%b sel=%0d ar=%b br=%b cnt=%0d, want 1 %0d %0d %0d %0d",
                         k, write, writeregsel, a_ready, b_ready, conflict_cnt,
                         (k % 2 == 0) ? 1 : 6, (k % 2 == 0), (k % 2 == 1), k);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({write, writeregsel, pend_mask} !== {1'b1, 3'd1, 8'h02}) begin
            n_err++;
            $display("FAIL b2b_drain_a: got w=%b sel=%0d pend=%h, want 1 1 02", write, writeregsel, pend_mask);
        end
        @(negedge clk);
        n_vec++;
        if ({write, pend_mask, conflict_cnt} !== {1'b0, 8'h00, 8'd10}) begin
            n_err++;
            $display("FAIL b2b_empty: got w=%b pend=%h cnt=%0d, want 0 00 10", write, pend_mask, conflict_cnt);
        end
    endtask

    task automatic test_same_reg();
        do_reset();
        a_valid = 1'b1; a_sel = 3'd5; a_data = 16'h0001;
        b_valid = 1'b1; b_sel = 3'd5; b_data = 16'h0002;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        n_vec++;
        if ({write, writeregsel, writedata, pend_mask} !== {1'b1, 3'd5, 16'h0001, 8'h20}) begin
            n_err++;
            $display("FAIL same_reg_first: got w=%b sel=%0d data=%h pend=%h, want 1 5 0001 20",
                     write, writeregsel, writedata, pend_mask);
        end
        @(negedge clk);
        n_vec++;
        if ({write, writeregsel, writedata} !== {1'b1, 3'd5, 16'h0002}) begin
            n_err++;
            $display("FAIL same_reg_second: got w=%b sel=%0d data=%h, want 1 5 0002", write, writeregsel, writedata);
        end
        @(negedge clk);
        n_vec++;
        if (rf_model[5] !== 16'h0002) begin
            n_err++;
            $display("FAIL same_reg_final: got r5=%h, want 0002", rf_model[5]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rf_model[4] = 16'h7777;
        rf_model[2] = 16'h7777;
        a_valid = 1'b1; a_sel = 3'd4; a_data = 16'hDEAD;
        b_valid = 1'b1; b_sel = 3'd2; b_data = 16'hFACE;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if (write !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_write: got w=%b, want 0", write);
        end
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({write, pend_mask, conflict_cnt, rf_model[4], rf_model[2]} !== {1'b0, 8'h00, 8'd0, 16'h7777, 16'h7777}) begin
            n_err++;
            $display("FAIL rst_mid_after: got w=%b pend=%h cnt=%0d r4=%h r2=%h, want 0 00 0 7777 7777",
                     write, pend_mask, conflict_cnt, rf_model[4], rf_model[2]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        a_valid = 1'b1; a_sel = 3'd0; a_data = 16'h1111;
        b_valid = 1'b1; b_sel = 3'd1; b_data = 16'h2222;
        repeat (300) @(negedge clk);
        n_vec++;
        if (conflict_cnt !== 8'hFF) begin
            n_err++;
            $display("FAIL cnt_saturate: got cnt=%h, want ff", conflict_cnt);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({conflict_cnt, write} !== {8'hFF, 1'b0}) begin
            n_err++;
            $display("FAIL cnt_hold: got cnt=%h w=%b, want ff 0", conflict_cnt, write);
        end
    endtask

`ifdef RF_WR_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        rd1sel = 3'd4; rf_rd1data = 16'h0000;
        rd2sel = 3'd3; rf_rd2data = 16'h3333;
        b_valid = 1'b1; b_sel = 3'd4; b_data = 16'hBEEF;
        @(negedge clk);
        b_valid = 1'b0;
        n_vec++;
        if ({rd1data, rd2data} !== {16'hBEEF, 16'h3333}) begin
            n_err++;
            $display("FAIL bypass_hit: got rd1=%h rd2=%h, want beef 3333", rd1data, rd2data);
        end
        @(negedge clk);
        n_vec++;
        if (rd1data !== 16'h0000) begin
            n_err++;
            $display("FAIL bypass_after: got rd1=%h, want 0000", rd1data);
        end
        a_valid = 1'b1; a_sel = 3'd4; a_data = 16'h00AA;
        b_valid = 1'b1; b_sel = 3'd4; b_data = 16'h00BB;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        n_vec++;
        if (rd1data !== 16'h00BB) begin
            n_err++;
            $display("FAIL bypass_both: got rd1=%h, want 00bb", rd1data);
        end
        @(negedge clk);
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) rf_model[i] = '0;
`ifdef RF_WR_BYPASS_EN
        rd1sel = '0; rd2sel = '0; rf_rd1data = '0; rf_rd2data = '0;
`endif
        test_reset();
        test_single_a();
        test_dual_accept();
        test_back_to_back();
        test_same_reg();
        test_reset_mid();
        test_saturate();
`ifdef RF_WR_BYPASS_EN
        test_bypass();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
